// File: rtl/udp_rx.sv
// rtl/udp_rx.sv - UDP receive stage: header parse, destination-port filter, payload forward
// Optional feature macro: UDP_RX_DROP_CNT_EN (saturating discarded-datagram counter on o_drop_cnt)
module udp_rx #(
  parameter logic [15:0] P_LOCAL_PORT = 16'd8080
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_local_port,
  input  logic        i_local_port_valid,
  input  logic [7:0]  i_udp_data,
  input  logic [15:0] i_udp_len,
  input  logic        i_udp_last,
  input  logic        i_udp_valid,
  output logic [7:0]  o_user_data,
  output logic [15:0] o_user_len,
  output logic        o_user_last,
  output logic        o_user_valid,
  output logic [15:0] o_src_port,
  output logic [15:0] o_drop_cnt
);

  typedef enum logic [2:0] {
    S_SYNC    = 3'd0,
    S_IDLE    = 3'd1,
    S_HEADER  = 3'd2,
    S_PAYLOAD = 3'd3,
    S_DISCARD = 3'd4
  } state_t;

  state_t      state_q, state_d;

  logic [15:0] local_port_q;   // programmable port, used from the next datagram on
  logic [15:0] port_lat_q;     // port snapshot taken at header byte 0
  logic [15:0] ulen_lat_q;     // IP-stage datagram length snapshot
  logic [15:0] src_q;
  logic [15:0] dst_q;
  logic [15:0] lfield_q;       // UDP length field L
  logic [15:0] rem_q;          // payload bytes still to forward
  logic [2:0]  hdr_cnt_q;      // index of the next header byte

  logic [7:0]  user_data_q;
  logic        user_valid_q;
  logic        user_last_q;
  logic [15:0] user_len_q;
  logic [15:0] src_out_q;

  logic        hdr_ok;
  logic        hdr_done;
  logic        start_pay;
  logic        pay_byte;
  logic        out_last;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_SYNC;
    else       state_q <= state_d;
  end

  // Next-state decision
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SYNC:    if (!i_udp_valid) state_d = S_IDLE;
      S_IDLE:    if (i_udp_valid && !i_udp_last) state_d = S_HEADER;
      S_HEADER: begin
        if (i_udp_valid) begin
          if (i_udp_last)    state_d = S_IDLE;
          else if (hdr_done) state_d = start_pay ? S_PAYLOAD : S_DISCARD;
        end
      end
      S_PAYLOAD: begin
        if (i_udp_valid) begin
          if (i_udp_last)            state_d = S_IDLE;
          else if (rem_q == 16'd1)   state_d = S_DISCARD;
        end
      end
      S_DISCARD: if (i_udp_valid && i_udp_last) state_d = S_IDLE;
      default:   state_d = S_SYNC;
    endcase
  end

  // Per-cycle decode: header verdict, payload forwarding and end-of-payload marker
  always_comb begin
    hdr_ok    = (dst_q == port_lat_q) && (lfield_q >= 16'd8) && (lfield_q <= ulen_lat_q);
    hdr_done  = 1'b0;
    start_pay = 1'b0;
    pay_byte  = 1'b0;
    out_last  = 1'b0;
    case (state_q)
      S_HEADER: begin
        if (i_udp_valid && (hdr_cnt_q == 3'd7)) begin
          hdr_done  = 1'b1;
          start_pay = hdr_ok && (lfield_q != 16'd8);
        end
      end
      S_PAYLOAD: begin
        if (i_udp_valid) begin
          pay_byte = 1'b1;
          out_last = i_udp_last || (rem_q == 16'd1);
        end
      end
      default: ;
    endcase
  end

  // Header capture, port/length snapshots and payload countdown
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      local_port_q <= P_LOCAL_PORT;
      port_lat_q   <= 16'd0;
      ulen_lat_q   <= 16'd0;
      src_q        <= 16'd0;
      dst_q        <= 16'd0;
      lfield_q     <= 16'd0;
      rem_q        <= 16'd0;
      hdr_cnt_q    <= 3'd0;
    end else begin
      if (i_local_port_valid) local_port_q <= i_local_port;
      if ((state_q == S_IDLE) && i_udp_valid) begin
        port_lat_q   <= local_port_q;
        ulen_lat_q   <= i_udp_len;
        src_q[15:8]  <= i_udp_data;
        hdr_cnt_q    <= 3'd1;
      end
      if ((state_q == S_HEADER) && i_udp_valid) begin
        hdr_cnt_q <= hdr_cnt_q + 3'd1;
        case (hdr_cnt_q)
          3'd1:    src_q[7:0]     <= i_udp_data;
          3'd2:    dst_q[15:8]    <= i_udp_data;
          3'd3:    dst_q[7:0]     <= i_udp_data;
          3'd4:    lfield_q[15:8] <= i_udp_data;
          3'd5:    lfield_q[7:0]  <= i_udp_data;
          default: ;
        endcase
      end
      if (start_pay)     rem_q <= lfield_q - 16'd8;
      else if (pay_byte) rem_q <= rem_q - 16'd1;
    end
  end

  // User-side output register; length and source port held until the next accepted datagram
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      user_data_q  <= 8'd0;
      user_valid_q <= 1'b0;
      user_last_q  <= 1'b0;
      user_len_q   <= 16'd0;
      src_out_q    <= 16'd0;
    end else begin
      user_valid_q <= pay_byte;
      user_last_q  <= out_last;
      if (pay_byte) user_data_q <= i_udp_data;
      if (start_pay) begin
        user_len_q <= lfield_q - 16'd8;
        src_out_q  <= src_q;
      end
    end
  end

  assign o_user_data  = user_data_q;
  assign o_user_valid = user_valid_q;
  assign o_user_last  = user_last_q;
  assign o_user_len   = user_len_q;
  assign o_src_port   = src_out_q;

`ifdef UDP_RX_DROP_CNT_EN
  logic        drop_evt;
  logic        drop_q;
  logic [15:0] drop_cnt_q;

  // A datagram is dropped at most once: each case below fires on a byte that ends its header/payload phase
  assign drop_evt = i_udp_valid && (
      ((state_q == S_IDLE) && i_udp_last) ||
      ((state_q == S_HEADER) && (hdr_done ? (!hdr_ok || (start_pay && i_udp_last)) : i_udp_last)) ||
      (pay_byte && i_udp_last && (rem_q != 16'd1)));

  // Saturating drop counter, bumped the cycle after the decision
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      drop_q     <= 1'b0;
      drop_cnt_q <= 16'd0;
    end else begin
      drop_q <= drop_evt;
      if (drop_q && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign o_drop_cnt = drop_cnt_q;
`else
  assign o_drop_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_udp_rx.sv
// tb/tb_udp_rx.sv - self-checking bench for udp_rx against a datagram-level reference model
module tb_udp_rx;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  data;
    logic        last;
    logic [15:0] len;
    logic [15:0] src;
  } out_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i_local_port;
  logic        i_local_port_valid;
  logic [7:0]  i_udp_data;
  logic [15:0] i_udp_len;
  logic        i_udp_last;
  logic        i_udp_valid;
  logic [7:0]  o_user_data;
  logic [15:0] o_user_len;
  logic        o_user_last;
  logic        o_user_valid;
  logic [15:0] o_src_port;
  logic [15:0] o_drop_cnt;

  udp_rx dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_local_port       (i_local_port),
    .i_local_port_valid (i_local_port_valid),
    .i_udp_data         (i_udp_data),
    .i_udp_len          (i_udp_len),
    .i_udp_last         (i_udp_last),
    .i_udp_valid        (i_udp_valid),
    .o_user_data        (o_user_data),
    .o_user_len         (o_user_len),
    .o_user_last        (o_user_last),
    .o_user_valid       (o_user_valid),
    .o_src_port         (o_src_port),
    .o_drop_cnt         (o_drop_cnt)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   bad_last = 0;
  int   exp_drops = 0;
  logic [15:0] cur_port = 16'h1F90;
  out_t got_q[$];
  out_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every forwarded byte with the cycle it was seen
  always @(negedge clk) begin
    if (o_user_valid) got_q.push_back({32'(cyc), o_user_data, o_user_last, o_user_len, o_src_port});
    if (o_user_last && !o_user_valid) bad_last++;
  end

  function automatic logic [15:0] exp_cnt();
`ifdef UDP_RX_DROP_CNT_EN
    return (exp_drops > 65535) ? 16'hFFFF : 16'(exp_drops);
`else
    return 16'd0;
`endif
  endfunction

  function automatic bq_t mk_dg(input logic [15:0] src, input logic [15:0] dst,
                                input logic [15:0] l, input bq_t pl);
    bq_t b;
    b = {};
    b.push_back(src[15:8]); b.push_back(src[7:0]);
    b.push_back(dst[15:8]); b.push_back(dst[7:0]);
    b.push_back(l[15:8]);   b.push_back(l[7:0]);
    b.push_back(8'($urandom)); b.push_back(8'($urandom));
    foreach (pl[i]) b.push_back(pl[i]);
    return b;
  endfunction

  // Reference: what a datagram of these bytes should produce, from the header rules alone
  function automatic void model(input bq_t b, input int cycs[$], input logic [15:0] ulen,
                                input logic [15:0] port);
    int          n;
    int          l;
    int          p;
    int          avail;
    int          k;
    logic [15:0] src;
    logic [15:0] dst;
    bit          drop;
    n = b.size();
    drop = 0;
    if (n < 8) drop = 1;
    else begin
      src = {b[0], b[1]};
      dst = {b[2], b[3]};
      l   = int'({b[4], b[5]});
      if (dst != port || l < 8 || l > int'(ulen)) drop = 1;
      else begin
        p = l - 8;
        avail = n - 8;
        k = (p < avail) ? p : avail;
        drop = (avail < p);
        for (int j = 0; j < k; j++)
          exp_q.push_back({32'(cycs[8+j] + 1), b[8+j], (j == k - 1), 16'(p), src});
      end
    end
    if (drop) exp_drops++;
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_dg(input bq_t b, input logic [15:0] ulen, input int gap_pct,
                          input bit lp_en, input logic [15:0] lp_val);
    int cycs[$];
    for (int i = 0; i < b.size(); i++) begin
      while (i > 0 && gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        i_udp_valid = 1'b0; i_udp_last = 1'b0; i_udp_data = 8'($urandom);
        step(1);
      end
      i_udp_data = b[i]; i_udp_valid = 1'b1; i_udp_last = (i == b.size() - 1); i_udp_len = ulen;
      if (lp_en && i == 0) begin i_local_port = lp_val; i_local_port_valid = 1'b1; end
      cycs.push_back(cyc);
      step(1);
      i_local_port_valid = 1'b0; i_udp_valid = 1'b0; i_udp_last = 1'b0;
    end
    model(b, cycs, ulen, cur_port);
    if (lp_en) cur_port = lp_val;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_local_port = 16'd0; i_local_port_valid = 1'b0;
    i_udp_data = 8'd0; i_udp_len = 16'd0; i_udp_last = 1'b0; i_udp_valid = 1'b0;
    step(3);
    n_chk++;
    if ({o_user_valid, o_user_last, o_user_data, o_user_len, o_src_port, o_drop_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b last=%b data=%h len=%h src=%h drop=%h required all 0",
               o_user_valid, o_user_last, o_user_data, o_user_len, o_src_port, o_drop_cnt);
    end
    rst = 1'b0; exp_drops = 0; cur_port = 16'h1F90;
    step(2);
    n_chk++;
    if (o_user_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_valid: got %b required 0", o_user_valid);
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_good();
    bq_t pl;
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    drive_dg(mk_dg(16'h04D2, 16'h1F90, 16'h000C, pl), 16'd12, 0, 0, 16'h0);
    step(3);
    n_chk++;
    if ({o_user_len, o_src_port} !== {16'd4, 16'h04D2}) begin
      n_fail++; $display("FAIL good_held_len_src: got %h/%h required 0004/04d2", o_user_len, o_src_port);
    end
    drive_dg(mk_dg(16'h04D2, 16'h1F90, 16'h000C, pl), 16'd12, 40, 0, 16'h0);
    drive_dg(mk_dg(16'h0A0B, 16'h1F90, 16'h000A, pl), 16'd12, 0, 0, 16'h0);
    drive_dg(mk_dg(16'h0C0D, 16'h1F90, 16'h0008, pl), 16'd12, 0, 0, 16'h0);
    drive_dg(mk_dg(16'h0E0F, 16'h1F90, 16'h000C, pl), 16'd12, 25, 0, 16'h0);
    step(4);
    n_chk++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL good_nbytes: got %0d required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < got_q.size()) begin
        n_chk++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL good_out[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    n_chk++;
    if (o_drop_cnt !== exp_cnt()) begin
      n_fail++; $display("FAIL good_drop_cnt: got %0d required %0d", o_drop_cnt, exp_cnt());
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_drops();
    bq_t pl;
    bq_t b;
    pl = '{8'h01, 8'h02, 8'h03, 8'h04};
    drive_dg(mk_dg(16'h04D2, 16'h1F91, 16'h000C, pl), 16'd12, 0, 0, 16'h0);
    drive_dg(mk_dg(16'h04D2, 16'h1F90, 16'h000C, pl), 16'd12, 0, 0, 16'h0);
    b = mk_dg(16'h1111, 16'h1F90, 16'h000C, pl);
    while (b.size() > 6) void'(b.pop_back());
    drive_dg(b, 16'd12, 0, 0, 16'h0);
    drive_dg(mk_dg(16'h2222, 16'h1F90, 16'h000C, pl), 16'd12, 0, 0, 16'h0);
    b = mk_dg(16'h3333, 16'h1F90, 16'h000C, pl);
    void'(b.pop_back());
    drive_dg(b, 16'd12, 10, 0, 16'h0);
    drive_dg(mk_dg(16'h4444, 16'h1F90, 16'h0007, pl), 16'd12, 0, 0, 16'h0);
    drive_dg(mk_dg(16'h5555, 16'h1F90, 16'h000D, pl), 16'd12, 0, 0, 16'h0);
    step(4);
    n_chk++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL drops_nbytes: got %0d required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < got_q.size()) begin
        n_chk++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL drops_out[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    n_chk++;
    if (o_drop_cnt !== exp_cnt()) begin
      n_fail++; $display("FAIL drops_drop_cnt: got %0d required %0d", o_drop_cnt, exp_cnt());
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_port_reprogram();
    bq_t pl;
    pl = '{8'h5A, 8'hA5};
    i_local_port = 16'h0035; i_local_port_valid = 1'b1;
    step(1);
    i_local_port_valid = 1'b0; cur_port = 16'h0035;
    drive_dg(mk_dg(16'h0101, 16'h0035, 16'd10, pl), 16'd10, 0, 0, 16'h0);
    drive_dg(mk_dg(16'h0202, 16'h1F90, 16'd10, pl), 16'd10, 0, 0, 16'h0);
    step(1);
    drive_dg(mk_dg(16'h0303, 16'h0035, 16'd10, pl), 16'd10, 20, 1, 16'h1F90);
    drive_dg(mk_dg(16'h0404, 16'h1F90, 16'd10, pl), 16'd10, 0, 0, 16'h0);
    step(4);
    n_chk++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL port_nbytes: got %0d required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < got_q.size()) begin
        n_chk++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL port_out[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    n_chk++;
    if (o_drop_cnt !== exp_cnt()) begin
      n_fail++; $display("FAIL port_drop_cnt: got %0d required %0d", o_drop_cnt, exp_cnt());
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    bq_t pl;
    bq_t b;
    int  c8;
    pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    b = mk_dg(16'h1234, 16'h1F90, 16'd16, pl);
    c8 = 0;
    for (int i = 0; i < 16; i++) begin
      i_udp_data = b[i]; i_udp_valid = 1'b1; i_udp_last = (i == 15); i_udp_len = 16'd16;
      if (i == 8) c8 = cyc;
      if (i == 10) begin
        rst = 1'b1;
        #1;
        n_chk++;
        if ({o_user_valid, o_user_last, o_user_data, o_user_len, o_src_port, o_drop_cnt} !== '0) begin
          n_fail++;
          $display("FAIL midreset_clear: got valid=%b data=%h len=%h src=%h drop=%h required all 0",
                   o_user_valid, o_user_data, o_user_len, o_src_port, o_drop_cnt);
        end
      end
      if (i == 12) rst = 1'b0;
      step(1);
    end
    i_udp_valid = 1'b0; i_udp_last = 1'b0;
    step(1);
    exp_q.push_back({32'(c8 + 1), 8'h11, 1'b0, 16'd8, 16'h1234});
    exp_drops = 0; cur_port = 16'h1F90;
    pl = '{8'hA1, 8'hA2, 8'hA3};
    drive_dg(mk_dg(16'h0BEE, 16'h1F90, 16'd11, pl), 16'd11, 0, 0, 16'h0);
    step(4);
    n_chk++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL midreset_nbytes: got %0d required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < got_q.size()) begin
        n_chk++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL midreset_out[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    n_chk++;
    if (o_drop_cnt !== exp_cnt()) begin
      n_fail++; $display("FAIL midreset_drop_cnt: got %0d required %0d", o_drop_cnt, exp_cnt());
    end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    for (int d = 0; d < 40; d++) begin
      int          p;
      int          kind;
      int          n;
      bit          lp;
      logic [15:0] l;
      logic [15:0] ul;
      logic [15:0] dst;
      bq_t         pl;
      bq_t         b;
      p = int'($urandom_range(0, 10));
      kind = int'($urandom_range(0, 5));
      dst = cur_port;
      l = 16'(8 + p);
      ul = l;
      case (kind)
        1: ul = l + 16'($urandom_range(1, 3));
        2: l = ul + 16'($urandom_range(1, 3));
        3: l = 16'($urandom_range(0, 7));
        4: dst = cur_port ^ (16'd1 << $urandom_range(0, 15));
        default: ;
      endcase
      pl = {};
      for (int j = 0; j < int'(ul) - 8; j++) pl.push_back(8'($urandom));
      b = mk_dg(16'($urandom), dst, l, pl);
      if ($urandom_range(0, 4) == 0) begin
        n = int'($urandom_range(1, b.size() - 1));
        while (b.size() > n) void'(b.pop_back());
      end
      lp = ($urandom_range(0, 7) == 0);
      drive_dg(b, ul, int'($urandom_range(0, 40)), lp,
               ($urandom_range(0, 1) == 1) ? 16'h1F90 : 16'h0035);
      step(int'($urandom_range(0, 2)));
    end
    step(4);
    n_chk++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL random_nbytes: got %0d required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      if (i < got_q.size()) begin
        n_chk++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL random_out[%0d]: got %h required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    n_chk++;
    if (o_drop_cnt !== exp_cnt()) begin
      n_fail++; $display("FAIL random_drop_cnt: got %0d required %0d", o_drop_cnt, exp_cnt());
    end
    n_chk++;
    if (bad_last !== 0) begin
      n_fail++; $display("FAIL last_without_valid: got %0d cycles required 0", bad_last);
    end
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_good();
    test_drops();
    test_port_reprogram();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
